seg7_share_ctrl: RTL and testbench
==================================

SEG7_SHARE_CTRL -- requirements
Module: seg7_share_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 25000, meaning clk cycles per digit slot (min 2).
REQ-002 The block SHALL have parameter HOLD_FRAMES, default 50, meaning minimum full scan frames an owner keeps the display when others wait (min 1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-005 The block SHALL have port req, input, 3 bits: per-requester display request, level-held.
REQ-006 The block SHALL have port req_bcd, input, 48 bits: packed 4-digit BCD per requester, requester i at [16i+15:16i], digit0 = units in the low nibble.
REQ-007 The block SHALL have port req_ndig, input, 9 bits: packed 3-bit digit count per requester, i at [3i+2:3i].
REQ-008 The block SHALL have port an_scan, output, 4 bits: active-low anode enables.
REQ-009 The block SHALL have port num, output, 4 bits: BCD value for the enabled digit.
REQ-010 The block SHALL have port grant, output, 3 bits: one-hot current owner, all zero when none.
REQ-011 The block SHALL have port busy, output, 1 bit: high in SCAN or SWITCH.

Function
REQ-012 An internal tick SHALL pulse for one cycle every CLK_DIV clk cycles, and all state, an_scan, num and grant updates SHALL occur only on tick cycles.
REQ-013 The FSM SHALL have the states IDLE, SCAN and SWITCH.
REQ-014 In IDLE, an_scan SHALL be 4'b1111 and grant SHALL be 0; on a tick with any req high, the FSM SHALL grant the winner, enter SCAN and drive digit 0 on that same tick.
REQ-015 The winner SHALL be chosen round-robin: search starts at the requester after the last owner; after reset the pointer equals 2, so req0 has priority.
REQ-016 On grant, the owner's ndig SHALL be latched, with 0 treated as 1 and values above 4 treated as 4; the latched count SHALL be held until the owner is released.
REQ-017 In SCAN, each tick SHALL advance the digit index d through 0..ndig-1 and wrap, with an_scan = ~(1<<d) and num = the owner's nibble d sampled live on that tick.
REQ-018 A frame SHALL end on the tick that displays the last digit (d = ndig-1), and hold_cnt SHALL increment at each frame end, saturating at HOLD_FRAMES.
REQ-019 At a frame end, if the owner's req is low, the FSM SHALL go to SWITCH when any other req is high and to IDLE otherwise, clearing grant in both cases.
REQ-020 At a frame end, if hold_cnt has reached HOLD_FRAMES and another req is high, the FSM SHALL go to SWITCH even if the owner's req is still high.
REQ-021 In all other cases the owner SHALL continue indefinitely, with hold_cnt saturated.
REQ-022 A req drop mid-frame SHALL take effect only at the frame end, so no frame is truncated.
REQ-023 SWITCH SHALL last exactly one slot, blanking an_scan to 4'b1111 with grant 0, as an anti-ghosting gap.
REQ-024 On the tick ending SWITCH, the FSM SHALL re-arbitrate over current req (the previous owner is eligible last) and go to SCAN digit 0, or to IDLE if req is 0.
REQ-025 On a new grant, hold_cnt SHALL reset to 0 and d SHALL reset to 0.
REQ-026 num SHALL be 0 whenever an_scan = 4'b1111.

Reset
REQ-027 When rst is high at a clk edge, the block SHALL set an_scan=4'b1111, num=0, grant=0, busy=0, state=IDLE, prescaler=0, hold_cnt=0, d=0 and rr pointer=2.
REQ-028 Reset mid-SCAN or mid-SWITCH SHALL abort immediately, with no blanking slot required.
REQ-029 After rst deasserts, the first tick SHALL occur CLK_DIV cycles later.

Structure
REQ-030 Package seg7_pkg SHALL hold the state encoding, the ANODE_OFF=4'b1111 constant, MAX_DIGITS=4 and NUM_REQ=3.
REQ-031 The prescaler SHALL be a sub-module seg7_tick_gen (clk, rst, tick), parameterised by CLK_DIV.

Verification (CLK_DIV=4, HOLD_FRAMES=2)
REQ-032 With req=001, bcd0=16'h1234 and ndig0=4, the bench SHALL check that the first tick gives grant=001, an_scan=1110, num=4, and the following ticks give 1101/3, 1011/2, 0111/1, then wrap.
REQ-033 With req0 owning and req1 asserted at frame 0, the bench SHALL check that after 2 complete frames there is one blank slot (an_scan=1111, grant=000), then grant=010.
REQ-034 With req=111 from reset, the bench SHALL check that grants rotate 001→010→100→001, each holding 2 frames, with one blank slot between owners.
REQ-035 With ndig0=0 and then 7, the bench SHALL check that display is 1 digit (an_scan constant 1110) and then 4 digits respectively.
REQ-036 When req0 drops at digit 1 of 4 with no other req, the bench SHALL check that digits 2 and 3 are still shown, then IDLE with busy=0 and an_scan=1111.
REQ-037 When rst is asserted mid-SWITCH, the bench SHALL check that all outputs take their reset values on the next edge, and with req=010 pending the first post-reset grant is 010 at tick 1.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the shared 4-digit seven-segment scan controller.
package seg7_pkg;

    localparam int         NUM_REQ    = 3;
    localparam int         MAX_DIGITS = 4;
    localparam logic [3:0] ANODE_OFF  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SCAN   = 2'b01,
        ST_SWITCH = 2'b10
    } seg7_state_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } rr_pick_t;

    // A requested digit count of 0 still shows one digit; anything beyond
    // the physical display is limited to the number of digits fitted.
    function automatic logic [2:0] clamp_ndig(input logic [2:0] raw);
        logic [2:0] res;
        if (raw == 3'd0) begin
            res = 3'd1;
        end else if (raw > 3'(MAX_DIGITS)) begin
            res = 3'(MAX_DIGITS);
        end else begin
            res = raw;
        end
        return res;
    endfunction

    // Round-robin search beginning at the requester after 'last', so the
    // previous owner is considered last.
    function automatic rr_pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                         input logic [1:0]         last);
        rr_pick_t   res;
        logic [1:0] cand;
        res.valid = 1'b0;
        res.idx   = 2'd0;
        cand      = last;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (cand >= 2'(NUM_REQ - 1)) ? 2'd0 : cand + 2'd1;
            if (!res.valid && req[cand]) begin
                res.valid = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_tick_gen.sv
// Slot prescaler: a registered one-cycle tick every CLK_DIV clock cycles.
module seg7_tick_gen #(
    parameter int CLK_DIV = 25000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int               CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    // The tick is registered, so it is raised one count early to land on
    // the CLK_DIV-th edge after reset release.
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLK_DIV - 2);

    logic [CNT_W-1:0] cnt_r;

    // Free-running modulo-CLK_DIV counter with registered tick decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
            tick  <= 1'b0;
        end else begin
            if (cnt_r == CNT_LAST) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            tick <= (cnt_r == CNT_PRE);
        end
    end

endmodule

// File: rtl/seg7_share_ctrl.sv
// One 4-digit multiplexed display shared round-robin between three requesters,
// with a minimum hold time per owner and a blank slot between owners.
module seg7_share_ctrl
    import seg7_pkg::*;
#(
    parameter int CLK_DIV     = 25000,
    parameter int HOLD_FRAMES = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [47:0] req_bcd,
    input  logic [8:0]  req_ndig,
    output logic [3:0]  an_scan,
    output logic [3:0]  num,
    output logic [2:0]  grant,
    output logic        busy
);

    localparam int                HOLD_W   = $clog2(HOLD_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES);

    logic              tick_s;
    seg7_state_e       state_r;
    logic [1:0]        owner_r;
    logic [1:0]        rr_ptr_r;
    logic [2:0]        ndig_r;
    logic [1:0]        d_r;
    logic [HOLD_W-1:0] hold_cnt_r;

    rr_pick_t          pick_s;
    logic [2:0]        win_ndig_raw_s;
    logic [2:0]        win_ndig_s;
    logic [15:0]       win_bcd_s;
    logic [15:0]       own_bcd_s;
    logic [1:0]        d_next_s;
    logic              last_digit_s;
    logic              next_last_s;
    logic              own_req_s;
    logic              other_req_s;
    logic [HOLD_W-1:0] hold_inc_s;

    seg7_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    // Arbitration candidate and its digit data, ready for the next tick.
    always_comb begin
        pick_s = rr_pick(req, rr_ptr_r);
        case (pick_s.idx)
            2'd0:    begin win_ndig_raw_s = req_ndig[2:0]; win_bcd_s = req_bcd[15:0];  end
            2'd1:    begin win_ndig_raw_s = req_ndig[5:3]; win_bcd_s = req_bcd[31:16]; end
            2'd2:    begin win_ndig_raw_s = req_ndig[8:6]; win_bcd_s = req_bcd[47:32]; end
            default: begin win_ndig_raw_s = 3'd0;          win_bcd_s = 16'h0000;       end
        endcase
        win_ndig_s = clamp_ndig(win_ndig_raw_s);
    end

    // Live digit data of the current owner.
    always_comb begin
        case (owner_r)
            2'd0:    own_bcd_s = req_bcd[15:0];
            2'd1:    own_bcd_s = req_bcd[31:16];
            2'd2:    own_bcd_s = req_bcd[47:32];
            default: own_bcd_s = 16'h0000;
        endcase
    end

    // Frame position, competing requests and saturating hold increment.
    always_comb begin
        d_next_s     = d_r + 2'd1;
        last_digit_s = ({1'b0, d_r} == (ndig_r - 3'd1));
        next_last_s  = ({1'b0, d_next_s} == (ndig_r - 3'd1));
        own_req_s    = |(req & grant);
        other_req_s  = |(req & ~grant);
        if (hold_cnt_r == HOLD_MAX) begin
            hold_inc_s = hold_cnt_r;
        end else begin
            hold_inc_s = hold_cnt_r + HOLD_W'(1);
        end
    end

    // Ownership FSM and registered display outputs, advanced once per slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            owner_r    <= 2'd0;
            rr_ptr_r   <= 2'd2;
            ndig_r     <= 3'd1;
            d_r        <= 2'd0;
            hold_cnt_r <= {HOLD_W{1'b0}};
            an_scan    <= ANODE_OFF;
            num        <= 4'd0;
            grant      <= 3'b000;
            busy       <= 1'b0;
        end else if (tick_s) begin
            case (state_r)
                ST_IDLE, ST_SWITCH: begin
                    if (pick_s.valid) begin
                        state_r    <= ST_SCAN;
                        owner_r    <= pick_s.idx;
                        rr_ptr_r   <= pick_s.idx;
                        ndig_r     <= win_ndig_s;
                        d_r        <= 2'd0;
                        // A one-digit owner completes its first frame right here.
                        hold_cnt_r <= (win_ndig_s == 3'd1) ? HOLD_W'(1) : {HOLD_W{1'b0}};
                        an_scan    <= 4'b1110;
                        num        <= win_bcd_s[3:0];
                        grant      <= 3'b001 << pick_s.idx;
                        busy       <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        an_scan <= ANODE_OFF;
                        num     <= 4'd0;
                        grant   <= 3'b000;
                        busy    <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (!last_digit_s) begin
                        // Mid-frame: keep scanning, request changes wait for the frame end.
                        d_r     <= d_next_s;
                        an_scan <= ~(4'b0001 << d_next_s);
                        num     <= own_bcd_s[{d_next_s, 2'b00} +: 4];
                        if (next_last_s) begin
                            hold_cnt_r <= hold_inc_s;
                        end
                    end else if (!own_req_s || ((hold_cnt_r == HOLD_MAX) && other_req_s)) begin
                        state_r <= other_req_s ? ST_SWITCH : ST_IDLE;
                        d_r     <= 2'd0;
                        an_scan <= ANODE_OFF;
                        num     <= 4'd0;
                        grant   <= 3'b000;
                        busy    <= other_req_s;
                    end else begin
                        d_r     <= 2'd0;
                        an_scan <= 4'b1110;
                        num     <= own_bcd_s[3:0];
                        if (ndig_r == 3'd1) begin
                            hold_cnt_r <= hold_inc_s;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    d_r     <= 2'd0;
                    an_scan <= ANODE_OFF;
                    num     <= 4'd0;
                    grant   <= 3'b000;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_share_ctrl.sv
// Self-checking bench for seg7_share_ctrl: directed scenarios plus random
// request/data traffic compared slot by slot against a behavioural model.
module tb_seg7_share_ctrl;

    localparam int CLK_DIV = 4;
    localparam int HOLD    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [47:0] req_bcd;
    logic [8:0]  req_ndig;
    logic [3:0]  an_scan;
    logic [3:0]  num;
    logic [2:0]  grant;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    // model state: mode 0 = idle, 1 = showing an owner, 2 = blank gap
    int   m_mode, m_owner, m_last, m_d, m_nd, m_frames;
    logic [3:0] exp_an, exp_num;
    logic [2:0] exp_grant;
    logic       exp_busy;

    seg7_share_ctrl #(
        .CLK_DIV     (CLK_DIV),
        .HOLD_FRAMES (HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_bcd  (req_bcd),
        .req_ndig (req_ndig),
        .an_scan  (an_scan),
        .num      (num),
        .grant    (grant),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp(input int v);
        if (v == 0) return 1;
        if (v > 4) return 4;
        return v;
    endfunction

    task automatic show();
        logic [47:0] t;
        t         = req_bcd >> (16 * m_owner + 4 * m_d);
        exp_an    = 4'hF & ~(4'h1 << m_d);
        exp_num   = t[3:0];
        exp_grant = 3'b001 << m_owner;
        exp_busy  = 1'b1;
    endtask

    task automatic blank();
        exp_an    = 4'hF;
        exp_num   = 4'h0;
        exp_grant = 3'b000;
        exp_busy  = (m_mode == 2);
    endtask

    task automatic model_reset();
        m_mode = 0; m_owner = 0; m_last = 2; m_d = 0; m_nd = 1; m_frames = 0;
        blank();
    endtask

    // One display slot according to the sharing rules.
    task automatic model_tick();
        bit own, oth;
        if (m_mode == 1) begin
            if (m_d < m_nd - 1) begin
                m_d++;
                if (m_d == m_nd - 1 && m_frames < HOLD) m_frames++;
                show();
            end else begin
                own = req[m_owner];
                oth = 1'b0;
                for (int i = 0; i < 3; i++) if (i != m_owner && req[i]) oth = 1'b1;
                if (!own || (m_frames >= HOLD && oth)) begin
                    m_mode = oth ? 2 : 0;
                    blank();
                end else begin
                    m_d = 0;
                    if (m_nd == 1 && m_frames < HOLD) m_frames++;
                    show();
                end
            end
        end else begin
            int found;
            found = -1;
            for (int k = 1; k <= 3; k++) begin
                int c;
                c = (m_last + k) % 3;
                if (found < 0 && req[c]) found = c;
            end
            if (found >= 0) begin
                m_owner  = found;
                m_last   = found;
                m_nd     = clamp(int'(req_ndig[3*found +: 3]));
                m_d      = 0;
                m_frames = (m_nd == 1) ? 1 : 0;
                m_mode   = 1;
                show();
            end else begin
                m_mode = 0;
                blank();
            end
        end
    endtask

    task automatic compare_all();
        check("an_scan", {12'h0, an_scan}, {12'h0, exp_an});
        check("num",     {12'h0, num},     {12'h0, exp_num});
        check("grant",   {13'h0, grant},   {13'h0, exp_grant});
        check("busy",    {15'h0, busy},    {15'h0, exp_busy});
    endtask

    // Called #1 after an edge; covers one slot, verifying outputs stay put mid-slot.
    task automatic run_slot();
        repeat (CLK_DIV / 2) @(posedge clk);
        #1;
        check("mid_an",    {12'h0, an_scan}, {12'h0, exp_an});
        check("mid_grant", {13'h0, grant},   {13'h0, exp_grant});
        repeat (CLK_DIV - CLK_DIV / 2) @(posedge clk);
        #1;
        model_tick();
        compare_all();
    endtask

    task automatic check_reset_vals();
        check("rst_an",    {12'h0, an_scan}, 16'h000F);
        check("rst_num",   {12'h0, num},     16'h0000);
        check("rst_grant", {13'h0, grant},   16'h0000);
        check("rst_busy",  {15'h0, busy},    16'h0000);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals();
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst      = 1'b1;
        req      = 3'b000;
        req_bcd  = 48'h0;
        req_ndig = {3'd4, 3'd4, 3'd4};

        // Basic scan of one requester
        req_bcd = {16'h9876, 16'h5555, 16'h1234};
        do_reset();
        req = 3'b001;
        run_slot();
        check("r32_an0",    {12'h0, an_scan}, 16'h000E);
        check("r32_num0",   {12'h0, num},     16'h0004);
        check("r32_grant0", {13'h0, grant},   16'h0001);
        run_slot();
        check("r32_an1",  {12'h0, an_scan}, 16'h000D);
        check("r32_num1", {12'h0, num},     16'h0003);
        run_slot();
        run_slot();
        check("r32_an3",  {12'h0, an_scan}, 16'h0007);
        check("r32_num3", {12'h0, num},     16'h0001);
        run_slot();
        check("r32_wrap", {12'h0, an_scan}, 16'h000E);

        // Hand-over after the hold time
        do_reset();
        req = 3'b011;
        for (int s = 1; s <= 11; s++) begin
            run_slot();
            if (s == 9)  check("r33_gap_an",  {12'h0, an_scan}, 16'h000F);
            if (s == 9)  check("r33_gap_gnt", {13'h0, grant},   16'h0000);
            if (s == 10) check("r33_next",    {13'h0, grant},   16'h0002);
        end

        // Full rotation with everyone requesting
        do_reset();
        req = 3'b111;
        for (int s = 1; s <= 28; s++) begin
            run_slot();
            if (s == 1)  check("r34_g1",  {13'h0, grant}, 16'h0001);
            if (s == 8)  check("r34_g8",  {13'h0, grant}, 16'h0001);
            if (s == 9)  check("r34_gap", {13'h0, grant}, 16'h0000);
            if (s == 10) check("r34_g10", {13'h0, grant}, 16'h0002);
            if (s == 19) check("r34_g19", {13'h0, grant}, 16'h0004);
            if (s == 28) check("r34_g28", {13'h0, grant}, 16'h0001);
        end

        // Digit count clamping
        do_reset();
        req_ndig = {3'd4, 3'd4, 3'd0};
        req = 3'b001;
        for (int s = 0; s < 5; s++) begin
            run_slot();
            check("r35_one", {12'h0, an_scan}, 16'h000E);
        end
        req = 3'b000;
        run_slot();
        run_slot();
        req_ndig = {3'd4, 3'd4, 3'd7};
        req = 3'b001;
        for (int s = 1; s <= 8; s++) begin
            run_slot();
            if (s == 4) check("r35_four", {12'h0, an_scan}, 16'h0007);
        end

        // Request drop mid-frame
        do_reset();
        req = 3'b001;
        run_slot();
        run_slot();
        req = 3'b000;
        run_slot();
        check("r36_d2", {12'h0, an_scan}, 16'h000B);
        run_slot();
        check("r36_d3", {12'h0, an_scan}, 16'h0007);
        run_slot();
        check("r36_idle_busy", {15'h0, busy},    16'h0000);
        check("r36_idle_an",   {12'h0, an_scan}, 16'h000F);

        // Reset while in the blank gap
        do_reset();
        req = 3'b011;
        for (int s = 1; s <= 9; s++) run_slot();
        check("r37_in_gap", {15'h0, busy}, 16'h0001);
        req = 3'b010;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals();
        rst = 1'b0;
        model_reset();
        run_slot();
        check("r37_first", {13'h0, grant}, 16'h0002);

        // Random traffic
        do_reset();
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) req_ndig = 9'($urandom);
            req_bcd = {16'($urandom), 32'($urandom)};
            run_slot();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
